// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative radix-2 multiply / restoring divide sequencer for EX.
// Ports: CLK, RST (sync, active-high); START, OP[1:0], SRC_A, SRC_B in;
//        BUSY, STALL, DONE, RESULT out. Optional macro: MULDIV_EARLY_OUT_EN.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] SRC_A,
    input  logic [WIDTH-1:0] SRC_B,
    output logic             BUSY,
    output logic             STALL,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] div_acc;
    logic [2*WIDTH-1:0] acc_nx;

    assign accept = START & (state_q != S_CALC);
    assign STALL  = (state_q == S_CALC) | accept;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;

    // Multiply: acc = {partial high, shifted-out low bits}; a_q is the
    // multiplicand, b_q the multiplier shifted right each step.
    assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};
    assign mul_acc = {sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, quotient}; the dividend lives in a_q and
    // feeds its MSB into the remainder each step.
    assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, b_q};
    assign div_acc = diff[WIDTH]
                   ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign acc_nx  = op_q[1] ? div_acc : mul_acc;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_CALC: begin
                acc_d = acc_nx;
                if (op_q[1]) begin
                    a_d = a_q << 1;
                end else begin
                    b_d = b_q >> 1;
                end
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    // OP[0] selects the upper half: MULH high word, REMU remainder.
                    result_d = op_q[0] ? acc_nx[2*WIDTH-1:WIDTH]
                                       : acc_nx[WIDTH-1:0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    op_d    = OP;
                    a_d     = SRC_A;
                    b_d     = SRC_B;
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    if (~|SRC_B[WIDTH-1:1]) begin
                        state_d = S_DONE;
                        case (OP)
                            2'b00:   result_d = SRC_B[0] ? SRC_A : '0;
                            2'b01:   result_d = '0;
                            2'b10:   result_d = SRC_B[0] ? SRC_A : '1;
                            default: result_d = SRC_B[0] ? '0 : SRC_A;
                        endcase
                    end
`endif
                end
            end
        endcase
        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: self-checking bench for muldiv_ctrl (WIDTH=32).
// Directed test-plan cases plus randomized ops against an arithmetic model.
module tb_muldiv_ctrl;

    localparam int W = 32;

    logic         CLK;
    logic         RST;
    logic         START;
    logic [1:0]   OP;
    logic [W-1:0] SRC_A;
    logic [W-1:0] SRC_B;
    logic         BUSY;
    logic         STALL;
    logic         DONE;
    logic [W-1:0] RESULT;

    int checks = 0;
    int errors = 0;

    logic [1:0]   cur_op;
    logic [W-1:0] cur_a;
    logic [W-1:0] cur_b;
    logic [W-1:0] last_res;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .OP     (OP),
        .SRC_A  (SRC_A),
        .SRC_B  (SRC_B),
        .BUSY   (BUSY),
        .STALL  (STALL),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (b <= 1) return 1;
`endif
        return W + 1;
    endfunction

    // Called at a negedge: raises START for the accept cycle.
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        START  = 1'b1;
        OP     = op;
        SRC_A  = a;
        SRC_B  = b;
        cur_op = op;
        cur_a  = a;
        cur_b  = b;
        #1;
        check("stall_accept", STALL, 1);
    endtask

    // Runs from the accept cycle to the DONE cycle; returns at DONE negedge.
    task automatic finish_op(input string tag, input bit toggle);
        int lat;
        int stl;
        logic [W-1:0] exp;
        exp = model(cur_op, cur_a, cur_b);
        stl = STALL ? 1 : 0;
        @(posedge CLK);
        #1;
        START = 1'b0;
        lat = 0;
        forever begin
            @(negedge CLK);
            lat++;
            if (DONE || lat >= 200) break;
            if (STALL) stl++;
            if (toggle) begin
                START = 1'($urandom);
                OP    = 2'($urandom);
                SRC_A = $urandom;
                SRC_B = $urandom;
            end
        end
        START = 1'b0;
        #1;
        check({tag, "_lat"}, lat, exp_lat(cur_b));
        check({tag, "_stall_cnt"}, stl, exp_lat(cur_b));
        check({tag, "_res"}, RESULT, exp);
        check({tag, "_stall_done"}, STALL, 0);
        last_res = exp;
    endtask

    task automatic idle_check(input string tag);
        @(negedge CLK);
        check({tag, "_idle_busy"}, BUSY, 0);
        check({tag, "_idle_done"}, DONE, 0);
        check({tag, "_idle_hold"}, RESULT, last_res);
    endtask

    initial begin
        int pulses;
        logic [W-1:0] a;
        logic [W-1:0] b;
        RST   = 1'b1;
        START = 1'b0;
        OP    = 2'b00;
        SRC_A = '0;
        SRC_B = '0;
        repeat (2) @(negedge CLK);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_result", RESULT, 0);
        check("rst_stall", STALL, 0);
        RST = 1'b0;
        @(negedge CLK);

        start_op(2'b00, 7, 6);
        finish_op("mul_7x6", 0);
        check("mul_42", RESULT, 42);
        idle_check("mul_7x6");

        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("mulh_ff", 0);
        check("mulh_fffe", RESULT, 32'hFFFF_FFFE);
        idle_check("mulh_ff");

        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("mul_ff", 0);
        idle_check("mul_ff");

        start_op(2'b10, 100, 7);
        finish_op("divu_100_7", 0);
        start_op(2'b11, 100, 7);
        finish_op("remu_b2b", 0);
        check("remu_2", RESULT, 2);
        idle_check("remu_b2b");

        start_op(2'b10, 32'h1234_5678, 0);
        finish_op("divu_by0", 0);
        idle_check("divu_by0");
        start_op(2'b11, 32'h1234_5678, 0);
        finish_op("remu_by0", 0);
        idle_check("remu_by0");

        start_op(2'b00, 7, 6);
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (10) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("rstcalc_busy", BUSY, 0);
        check("rstcalc_done", DONE, 0);
        check("rstcalc_result", RESULT, 0);
        check("rstcalc_stall", STALL, 0);
        pulses = 0;
        repeat (60) begin
            @(negedge CLK);
            if (DONE) pulses++;
        end
        check("rstcalc_no_done", pulses, 0);
        start_op(2'b00, 3, 5);
        finish_op("mul_3x5", 0);
        idle_check("mul_3x5");

        start_op(2'b10, 32'hDEAD_BEEF, 32'h0000_1234);
        finish_op("toggle", 1);
        idle_check("toggle");

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1))
                                            : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            start_op(2'($urandom), a, b);
            finish_op("rand", i[0]);
            if ($urandom_range(0, 1) == 0) idle_check("rand");
        end
        idle_check("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
